// File: rtl/output_cost_unit_if.sv
// Bus bundle for output_cost_unit.
// Groups the start request, latched operands and the result/cost outputs.
//   master: drives start, hiddenVec, Wout, target; observes results.
//   slave : the unit itself.
interface output_cost_unit_if #(
  parameter int unsigned HIDDEN_SZ = 8,
  parameter int unsigned OUTPUT_SZ = 1,
  parameter int unsigned QN        = 6,
  parameter int unsigned QM        = 11,
  parameter int unsigned BITWIDTH  = QN + QM + 1
);
  logic                                    start;
  logic [BITWIDTH*HIDDEN_SZ-1:0]           hiddenVec;
  logic [BITWIDTH*HIDDEN_SZ*OUTPUT_SZ-1:0] Wout;
  logic [BITWIDTH*OUTPUT_SZ-1:0]           target;
  logic                                    busy;
  logic                                    outValid;
  logic [BITWIDTH*OUTPUT_SZ-1:0]           netOut;
  logic                                    newCostFunc;
  logic [BITWIDTH-1:0]                     costFunc;

  modport master (
    output start, hiddenVec, Wout, target,
    input  busy, outValid, netOut, newCostFunc, costFunc
  );

  modport slave (
    input  start, hiddenVec, Wout, target,
    output busy, outValid, netOut, newCostFunc, costFunc
  );
endinterface

// File: rtl/output_cost_unit.sv
// Output layer and cost evaluator.
// Computes OUTPUT_SZ dot products of the hidden vector with the output weights on a
// single multiplier (one term per cycle), applies a shift-only piecewise-linear sigmoid
// and accumulates the squared error against the targets into a saturating cost.
// Ports:
//   clock - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - slave side of output_cost_unit_if (start/operands in, results out)
module output_cost_unit #(
  parameter int unsigned HIDDEN_SZ = 8,
  parameter int unsigned OUTPUT_SZ = 1,
  parameter int unsigned QN        = 6,
  parameter int unsigned QM        = 11,
  parameter int unsigned BITWIDTH  = QN + QM + 1
) (
  input logic               clock,
  input logic               reset,
  output_cost_unit_if.slave bus
);
  localparam int unsigned IDX_W  = $clog2(HIDDEN_SZ);
  localparam int unsigned CH_W   = (OUTPUT_SZ > 1) ? $clog2(OUTPUT_SZ) : 1;
  localparam int unsigned ACC_W  = BITWIDTH + IDX_W;
  localparam int unsigned PROD_W = 2 * BITWIDTH;
  localparam int unsigned SQ_W   = 2 * BITWIDTH + 2;
  localparam int unsigned HV_W   = BITWIDTH * HIDDEN_SZ;
  localparam int unsigned W_W    = HV_W * OUTPUT_SZ;
  localparam int unsigned T_W    = BITWIDTH * OUTPUT_SZ;

  localparam logic [IDX_W-1:0] J_LAST = IDX_W'(HIDDEN_SZ - 1);
  localparam logic [CH_W-1:0]  C_LAST = CH_W'(OUTPUT_SZ - 1);

  // Accumulator limits expressed at the wider MAC sum width so the add never wraps.
  localparam logic signed [PROD_W:0] ACC_MAX =
      {{(PROD_W + 2 - ACC_W){1'b0}}, {(ACC_W - 1){1'b1}}};
  localparam logic signed [PROD_W:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [ACC_W-1:0] Z_MAX =
      {{(ACC_W - BITWIDTH + 1){1'b0}}, {(BITWIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] Z_MIN = ~Z_MAX;

  localparam logic [BITWIDTH-1:0] POS_MAX = {1'b0, {(BITWIDTH - 1){1'b1}}};
  localparam logic [BITWIDTH-1:0] NEG_MIN = {1'b1, {(BITWIDTH - 1){1'b0}}};
  localparam logic [SQ_W-1:0]     COST_MAX = SQ_W'(POS_MAX);

  // Sigmoid breakpoints and offsets scaled to QM fraction bits.
  localparam logic [BITWIDTH-1:0] ONE     = BITWIDTH'(1) << QM;
  localparam logic [BITWIDTH-1:0] K_5P0   = BITWIDTH'(5) << QM;
  localparam logic [BITWIDTH-1:0] K_2P375 = BITWIDTH'(19) << (QM - 3);
  localparam logic [BITWIDTH-1:0] OFF_HI  = BITWIDTH'(27) << (QM - 5);
  localparam logic [BITWIDTH-1:0] OFF_MID = BITWIDTH'(5) << (QM - 3);
  localparam logic [BITWIDTH-1:0] HALF    = BITWIDTH'(1) << (QM - 1);

  typedef enum logic [2:0] {StIdle, StMac, StAct, StErr, StDone} state_e;

  state_e                    state_q, state_d;
  logic [HV_W-1:0]           h_q;
  logic [W_W-1:0]            w_q;
  logic [T_W-1:0]            t_q;
  logic [IDX_W-1:0]          j_q;
  logic [CH_W-1:0]           c_q;
  logic signed [ACC_W-1:0]   acc_q;
  logic [BITWIDTH-1:0]       cost_q;
  logic [BITWIDTH-1:0]       y_q;
  logic [T_W-1:0]            net_q;
  logic [BITWIDTH-1:0]       cost_out_q;
  logic                      valid_q;

  int unsigned               h_idx, w_idx, c_idx;
  logic signed [BITWIDTH-1:0] h_cur, w_cur, t_cur, z;
  logic signed [PROD_W-1:0]  prod, term;
  logic signed [PROD_W:0]    sum_w;
  logic signed [ACC_W-1:0]   acc_next;
  logic [BITWIDTH-1:0]       a, s, y;
  logic signed [BITWIDTH:0]  y_ext, t_ext, e;
  logic [SQ_W-1:0]           sq, cost_sum;
  logic [BITWIDTH-1:0]       cost_next;

  // Datapath shared by MAC, ACT and ERR.
  always_comb begin
    c_idx = 32'(c_q);
    h_idx = 32'(j_q) * BITWIDTH;
    w_idx = (c_idx * HIDDEN_SZ + 32'(j_q)) * BITWIDTH;
    h_cur = h_q[h_idx +: BITWIDTH];
    w_cur = w_q[w_idx +: BITWIDTH];
    t_cur = t_q[c_idx * BITWIDTH +: BITWIDTH];

    prod  = h_cur * w_cur;
    term  = prod >>> QM;
    sum_w = (PROD_W + 1)'(acc_q) + (PROD_W + 1)'(term);
    if (sum_w > ACC_MAX)      acc_next = ACC_MIN[ACC_W-1:0] ^ {ACC_W{1'b1}};
    else if (sum_w < ACC_MIN) acc_next = ACC_MIN[ACC_W-1:0];
    else                      acc_next = sum_w[ACC_W-1:0];

    if (acc_q > Z_MAX)      z = Z_MAX[BITWIDTH-1:0];
    else if (acc_q < Z_MIN) z = Z_MIN[BITWIDTH-1:0];
    else                    z = acc_q[BITWIDTH-1:0];

    // The most negative code has no positive twin; treat it as max positive.
    if (z == NEG_MIN)          a = POS_MAX;
    else if (z[BITWIDTH-1])    a = -z;
    else                       a = z;

    if (a >= K_5P0)        s = ONE;
    else if (a >= K_2P375) s = (a >> 5) + OFF_HI;
    else if (a >= ONE)     s = (a >> 3) + OFF_MID;
    else                   s = (a >> 2) + HALF;
    y = z[BITWIDTH-1] ? ONE - s : s;

    y_ext    = {1'b0, y_q};
    t_ext    = {t_cur[BITWIDTH-1], t_cur};
    e        = y_ext - t_ext;
    sq       = e * e;
    cost_sum = SQ_W'(cost_q) + (sq >> QM);
    cost_next = (cost_sum > COST_MAX) ? POS_MAX : cost_sum[BITWIDTH-1:0];
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.start) state_d = StMac;
      StMac:   if (j_q == J_LAST) state_d = StAct;
      StAct:   state_d = StErr;
      StErr:   state_d = (c_q == C_LAST) ? StDone : StMac;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      h_q        <= '0;
      w_q        <= '0;
      t_q        <= '0;
      j_q        <= '0;
      c_q        <= '0;
      acc_q      <= '0;
      cost_q     <= '0;
      y_q        <= '0;
      net_q      <= '0;
      cost_out_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            h_q    <= bus.hiddenVec;
            w_q    <= bus.Wout;
            t_q    <= bus.target;
            cost_q <= '0;
            acc_q  <= '0;
            c_q    <= '0;
            j_q    <= '0;
          end
        end
        StMac: begin
          acc_q <= acc_next;
          j_q   <= j_q + 1'b1;
        end
        StAct: begin
          y_q                            <= y;
          net_q[c_idx*BITWIDTH +: BITWIDTH] <= y;
        end
        StErr: begin
          cost_q <= cost_next;
          c_q    <= c_q + 1'b1;
          j_q    <= '0;
          acc_q  <= '0;
        end
        StDone: begin
          cost_out_q <= cost_q;
          valid_q    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state_q != StIdle);
  assign bus.outValid    = valid_q;
  assign bus.newCostFunc = valid_q;
  assign bus.netOut      = net_q;
  assign bus.costFunc    = cost_out_q;
endmodule
